monit_readout_ctrl: RTL and testbench

MONIT_READOUT_CTRL -- requirements
Module: monit_readout_ctrl

---
 rtl/monit_readout_pkg.sv | 46 ++++
 rtl/monit_readout_ctrl.sv | 135 +++++++++++++
 tb/tb_monit_readout_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/monit_readout_pkg.sv
// monit_readout_pkg -- shared definitions for the monitor-counter readout
// controller: FSM state type, default frame sync bytes, frame geometry and
// the field map of the packed 184-bit counter bus.
//
// Build option: MONIT_READOUT_CHKSUM_EN appends a modulo-256 payload checksum
// byte to every frame (26-byte frame instead of 25).
package monit_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] HDR0_DEFAULT = 8'hEB;
  localparam logic [7:0] HDR1_DEFAULT = 8'h90;

  localparam int CNT_BUS_W       = 184;
  localparam int HDR_BYTES       = 2;
  localparam int PAYLOAD_BYTES   = 23;
  localparam int FRAME_LEN_NOCHK = 25;
  localparam int FRAME_LEN_CHK   = 26;

`ifdef MONIT_READOUT_CHKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CHK;
`else
  localparam int FRAME_LEN = FRAME_LEN_NOCHK;
`endif

  // Byte index covers 0..FRAME_LEN-1.
  localparam int IDX_W = 5;

  // Field map of cnt_bus_in; the first payload byte is the MSB of the bus.
  localparam int HIT_MONIT_CNT_0_LSB = 152; localparam int HIT_MONIT_CNT_0_W = 32;
  localparam int HIT_MONIT_CNT_1_LSB = 120; localparam int HIT_MONIT_CNT_1_W = 32;
  localparam int HIT_START_LSB       = 104; localparam int HIT_START_W       = 16;
  localparam int LOGIC_MATCH_LSB     = 88;  localparam int LOGIC_MATCH_W     = 16;
  localparam int EFF_TRG_LSB         = 72;  localparam int EFF_TRG_W         = 16;
  localparam int COINCID_TRG_LSB     = 56;  localparam int COINCID_TRG_W     = 16;
  localparam int EXT_TRG_LSB         = 40;  localparam int EXT_TRG_W         = 16;
  localparam int BUSY_MONIT_LSB      = 24;  localparam int BUSY_MONIT_W      = 16;
  localparam int HIT_MONIT_ERR_LSB   = 16;  localparam int HIT_MONIT_ERR_W   = 8;
  localparam int HIT_MONIT_SEL_LSB   = 8;   localparam int HIT_MONIT_SEL_W   = 8;
  localparam int TRG_DELAY_TIMER_LSB = 0;   localparam int TRG_DELAY_TIMER_W = 8;

endpackage

// File: rtl/monit_readout_ctrl.sv
// monit_readout_ctrl -- snapshots the packed monitor counters on a readout
// request and streams them as a byte frame (HDR0, HDR1, 23 payload bytes
// MSB-first, optional checksum) over a valid/ready handshake.
//
// Build option: MONIT_READOUT_CHKSUM_EN adds the checksum byte as the last
// frame byte; without it the checksum logic is not built.
//
// Ports:
//   clk_in          system clock
//   rst_n_in        asynchronous active-low reset
//   req_in          readout request pulse
//   cnt_bus_in      packed monitor counters (184 bits)
//   data_out        current frame byte (0 when not sending)
//   data_valid_out  data_out is valid
//   data_ready_in   downstream accepts the byte
//   sof_out         first frame byte
//   eof_out         last frame byte
//   rd_out          one-cycle pulse after the frame
//   busy_out        high outside IDLE
//   overrun_cnt_out saturating count of requests dropped while busy
module monit_readout_ctrl
  import monit_readout_pkg::*;
#(
  parameter logic [7:0] HDR0 = HDR0_DEFAULT,
  parameter logic [7:0] HDR1 = HDR1_DEFAULT
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 req_in,
  input  logic [CNT_BUS_W-1:0] cnt_bus_in,
  output logic [7:0]           data_out,
  output logic                 data_valid_out,
  input  logic                 data_ready_in,
  output logic                 sof_out,
  output logic                 eof_out,
  output logic                 rd_out,
  output logic                 busy_out,
  output logic [7:0]           overrun_cnt_out
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] PAY_FIRST = IDX_W'(HDR_BYTES);

  state_t               state;
  logic [CNT_BUS_W-1:0] snapshot;
  logic [IDX_W-1:0]     idx;
  logic [7:0]           overrun_cnt;
  logic [IDX_W-1:0]     pay_idx;
  logic [CNT_BUS_W-1:0] pay_shift;
  logic [7:0]           pay_byte;
  logic [7:0]           frame_byte;

  // Payload byte k sits at the top of the snapshot shifted left by 8*k; for
  // header indices pay_idx wraps, but those indices never select pay_byte.
  assign pay_idx   = idx - PAY_FIRST;
  assign pay_shift = snapshot << {pay_idx, 3'b000};
  assign pay_byte  = pay_shift[CNT_BUS_W-1 -: 8];

`ifdef MONIT_READOUT_CHKSUM_EN
  localparam logic [IDX_W-1:0] PAY_LAST = IDX_W'(HDR_BYTES + PAYLOAD_BYTES - 1);
  logic [7:0] chksum;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      chksum <= '0;
    end else if (state == ST_IDLE && req_in) begin
      chksum <= '0;
    end else if (state == ST_SEND && data_ready_in &&
                 idx >= PAY_FIRST && idx <= PAY_LAST) begin
      chksum <= chksum + pay_byte;
    end
  end
`endif

  always_comb begin
    frame_byte = pay_byte;
    if (idx == '0) begin
      frame_byte = HDR0;
    end else if (idx == IDX_W'(1)) begin
      frame_byte = HDR1;
    end
`ifdef MONIT_READOUT_CHKSUM_EN
    else if (idx == LAST_IDX) begin
      frame_byte = chksum;
    end
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= ST_IDLE;
      idx      <= '0;
      snapshot <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_in) begin
            snapshot <= cnt_bus_in;
            idx      <= '0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (data_ready_in) begin
            if (idx == LAST_IDX) begin
              state <= ST_DONE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A request in DONE is still busy time, so it counts as an overrun.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      overrun_cnt <= '0;
    end else if (req_in && state != ST_IDLE && overrun_cnt != 8'hFF) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  assign data_valid_out  = (state == ST_SEND);
  assign data_out        = data_valid_out ? frame_byte : 8'h00;
  assign sof_out         = data_valid_out && (idx == '0);
  assign eof_out         = data_valid_out && (idx == LAST_IDX);
  assign rd_out          = (state == ST_DONE);
  assign busy_out        = (state != ST_IDLE);
  assign overrun_cnt_out = overrun_cnt;

endmodule

// File: tb/tb_monit_readout_ctrl.sv
// tb_monit_readout_ctrl -- randomized bench for monit_readout_ctrl with a
// field-level frame model (headers, MSB-first fields, modulo-256 sum).
// Follows the DUT build: define MONIT_READOUT_CHKSUM_EN for both or neither.
module tb_monit_readout_ctrl;
  import monit_readout_pkg::*;

  logic                 clk_in = 1'b0;
  logic                 rst_n_in;
  logic                 req_in;
  logic [CNT_BUS_W-1:0] cnt_bus_in;
  logic [7:0]           data_out;
  logic                 data_valid_out;
  logic                 data_ready_in;
  logic                 sof_out;
  logic                 eof_out;
  logic                 rd_out;
  logic                 busy_out;
  logic [7:0]           overrun_cnt_out;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         ovr_exp = 0;
  logic [7:0] expq[$];

  monit_readout_ctrl dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .req_in          (req_in),
    .cnt_bus_in      (cnt_bus_in),
    .data_out        (data_out),
    .data_valid_out  (data_valid_out),
    .data_ready_in   (data_ready_in),
    .sof_out         (sof_out),
    .eof_out         (eof_out),
    .rd_out          (rd_out),
    .busy_out        (busy_out),
    .overrun_cnt_out (overrun_cnt_out)
  );

  always #10 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CNT_BUS_W-1:0] rand_bus();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[CNT_BUS_W-1:0];
  endfunction

  // Expected frame: headers, then every field MSB-first, then the sum.
  task automatic build_exp(input logic [CNT_BUS_W-1:0] bus);
    int lsb [11];
    int wid [11];
    logic [7:0] sum;
    logic [7:0] byt;
    logic [CNT_BUS_W-1:0] v;
    lsb = '{HIT_MONIT_CNT_0_LSB, HIT_MONIT_CNT_1_LSB, HIT_START_LSB, LOGIC_MATCH_LSB,
            EFF_TRG_LSB, COINCID_TRG_LSB, EXT_TRG_LSB, BUSY_MONIT_LSB,
            HIT_MONIT_ERR_LSB, HIT_MONIT_SEL_LSB, TRG_DELAY_TIMER_LSB};
    wid = '{HIT_MONIT_CNT_0_W, HIT_MONIT_CNT_1_W, HIT_START_W, LOGIC_MATCH_W,
            EFF_TRG_W, COINCID_TRG_W, EXT_TRG_W, BUSY_MONIT_W,
            HIT_MONIT_ERR_W, HIT_MONIT_SEL_W, TRG_DELAY_TIMER_W};
    sum = 8'h00;
    expq.delete();
    expq.push_back(8'hEB);
    expq.push_back(8'h90);
    for (int f = 0; f < 11; f++) begin
      v = bus >> lsb[f];
      for (int b = wid[f] / 8 - 1; b >= 0; b--) begin
        byt = v[8*b +: 8];
        sum = sum + byt;
        expq.push_back(byt);
      end
    end
`ifdef MONIT_READOUT_CHKSUM_EN
    expq.push_back(sum);
`endif
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Pulse req_in in IDLE; returns #1 after the capture edge.
  task automatic start_frame(input logic [CNT_BUS_W-1:0] bus);
    cnt_bus_in = bus;
    build_exp(bus);
    req_in = 1'b1;
    @(posedge clk_in); #1;
    req_in = 1'b0;
    check("first_valid", 32'(data_valid_out), 32'd1);
    check("first_hdr0", 32'(data_out), 32'(expq[0]));
    check("first_sof", 32'(sof_out), 32'd1);
  endtask

  // mode 0: ready always, 1: ready toggles 1/0, 2: random ready.
  task automatic drain(input int mode, input bit chg, input int nreq, input bit done_req,
                       output int cycles);
    int  n;
    bit  rdy;
    n = 0;
    cycles = 0;
    while (n < expq.size() && cycles < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cycles % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      data_ready_in = rdy;
      if (chg) cnt_bus_in = rand_bus();
      req_in = (cycles >= 1 && cycles <= nreq);
      if (req_in) ovr_exp = sat_inc(ovr_exp);
      check("valid", 32'(data_valid_out), 32'd1);
      check("data", 32'(data_out), 32'(expq[n]));
      check("sof", 32'(sof_out), 32'(n == 0));
      check("eof", 32'(eof_out), 32'(n == expq.size() - 1));
      check("rd_in_send", 32'(rd_out), 32'd0);
      if (rdy) n++;
      @(posedge clk_in); #1;
      req_in = 1'b0;
      cycles++;
    end
    check("frame_done_in_budget", 32'(n), 32'(expq.size()));
    data_ready_in = 1'b0;
    check("done_rd", 32'(rd_out), 32'd1);
    check("done_valid", 32'(data_valid_out), 32'd0);
    check("done_busy", 32'(busy_out), 32'd1);
    req_in = done_req;
    if (done_req) ovr_exp = sat_inc(ovr_exp);
    @(posedge clk_in); #1;
    req_in = 1'b0;
    check("idle_rd", 32'(rd_out), 32'd0);
    check("idle_busy", 32'(busy_out), 32'd0);
    check("idle_valid", 32'(data_valid_out), 32'd0);
    check("overrun", 32'(overrun_cnt_out), 32'(ovr_exp));
  endtask

  initial begin
    int cyc;
    logic [CNT_BUS_W-1:0] bus;
    rst_n_in      = 1'b0;
    req_in        = 1'b0;
    data_ready_in = 1'b0;
    cnt_bus_in    = '0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_valid", 32'(data_valid_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    check("rst_ovr", 32'(overrun_cnt_out), 32'd0);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Directed counter pattern, ready held high.
    bus = '0;
    bus[HIT_MONIT_CNT_0_LSB +: 32] = 32'h01020304;
    start_frame(bus);
    drain(0, 1'b0, 0, 1'b0, cyc);
    check("len_ready_high", 32'(cyc), 32'(expq.size()));

    // Ready toggling 1/0: 2*len-1 cycles.
    start_frame(rand_bus());
    drain(1, 1'b0, 0, 1'b0, cyc);
    check("len_toggle", 32'(cyc), 32'(2 * expq.size() - 1));

    // Three requests during one frame, bus churning, then a request in DONE.
    start_frame(rand_bus());
    drain(2, 1'b1, 3, 1'b0, cyc);
    check("ovr_three", 32'(overrun_cnt_out), 32'd3);
    start_frame(rand_bus());
    drain(0, 1'b1, 0, 1'b1, cyc);
    repeat (3) begin
      @(posedge clk_in); #1;
      check("no_frame_after_done_req", 32'(busy_out), 32'd0);
    end

    // Random frames.
    for (int i = 0; i < 6; i++) begin
      start_frame(rand_bus());
      drain(2, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)), cyc);
    end

    // 300 overruns while stalled on HDR0.
    start_frame(rand_bus());
    data_ready_in = 1'b0;
    req_in = 1'b1;
    repeat (300) begin
      @(posedge clk_in); #1;
      ovr_exp = sat_inc(ovr_exp);
    end
    req_in = 1'b0;
    check("ovr_sat", 32'(overrun_cnt_out), 32'd255);
    check("stall_hold", 32'(data_out), 32'(expq[0]));
    drain(0, 1'b0, 0, 1'b0, cyc);

    // Reset in the middle of a frame.
    start_frame(rand_bus());
    data_ready_in = 1'b1;
    repeat (10) begin
      @(posedge clk_in); #1;
    end
    check("pre_rst_data", 32'(data_out), 32'(expq[10]));
    rst_n_in = 1'b0;
    #1;
    check("arst_valid", 32'(data_valid_out), 32'd0);
    check("arst_data", 32'(data_out), 32'd0);
    check("arst_sof_eof", 32'({sof_out, eof_out}), 32'd0);
    check("arst_busy_rd", 32'({busy_out, rd_out}), 32'd0);
    check("arst_ovr", 32'(overrun_cnt_out), 32'd0);
    ovr_exp = 0;
    data_ready_in = 1'b0;
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    repeat (3) begin
      @(posedge clk_in); #1;
      check("post_rst_no_rd", 32'({rd_out, busy_out}), 32'd0);
    end
    start_frame(rand_bus());
    drain(2, 1'b1, 1, 1'b0, cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
